// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - shared ALU op codes, request/response types and op legality check
package riscv_alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu_op;
    } alu_req_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } alu_rsp_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
            ALU_SRL, ALU_SLL, ALU_SRA, ALU_XOR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational RV32 integer ALU, shifts use op2[4:0]
module riscv_alu
    import riscv_alu_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  alu_op,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_AND: result = op1 & op2;
            ALU_OR:  result = op1 | op2;
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            ALU_SLT: result = {31'b0, ($signed(op1) < $signed(op2))};
            ALU_SRL: result = op1 >> shamt;
            ALU_SLL: result = op1 << shamt;
            ALU_SRA: result = $signed(op1) >>> shamt;
            ALU_XOR: result = op1 ^ op2;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/riscv_alu_rsp_slot.sv
// rtl/riscv_alu_rsp_slot.sv - single-entry valid/ready response register
module riscv_alu_rsp_slot
    import riscv_alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  alu_rsp_t load_data,
    input  logic     rsp_ready,
    output logic     rsp_valid,
    output alu_rsp_t rsp_data
);

    logic     valid_q, valid_d;
    alu_rsp_t data_q, data_d;

    // A load in the same cycle as a drain wins, so the slot reloads without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;

endmodule

// File: rtl/riscv_alu_arbiter.sv
// rtl/riscv_alu_arbiter.sv - two-port arbiter sharing one ALU with registered per-port responses
module riscv_alu_arbiter
    import riscv_alu_pkg::*;
#(
    parameter bit          RR_EN        = 1'b1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [31:0] p0_op1,
    input  logic [31:0] p0_op2,
    input  logic [3:0]  p0_alu_op,
    output logic        p0_rsp_valid,
    input  logic        p0_rsp_ready,
    output logic [31:0] p0_rsp_result,
    output logic        p0_rsp_zero,
    output logic        p0_rsp_illegal,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_op1,
    input  logic [31:0] p1_op2,
    input  logic [3:0]  p1_alu_op,
    output logic        p1_rsp_valid,
    input  logic        p1_rsp_ready,
    output logic [31:0] p1_rsp_result,
    output logic        p1_rsp_zero,
    output logic        p1_rsp_illegal
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    alu_req_t    req0, req1, alu_req;
    alu_rsp_t    rsp0, rsp1, cap_rsp;
    logic        elig0, elig1, grant0, grant1, force1;
    logic        rr_last_q, rr_last_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] alu_result;
    logic        alu_zero_unused;
    logic        op_legal;

    assign req0 = '{op1: p0_op1, op2: p0_op2, alu_op: p0_alu_op};
    assign req1 = '{op1: p1_op1, op2: p1_op2, alu_op: p1_alu_op};

    always_comb begin
        elig0        = p0_valid && (!p0_rsp_valid || p0_rsp_ready);
        elig1        = p1_valid && (!p1_rsp_valid || p1_rsp_ready);
        grant0       = 1'b0;
        grant1       = 1'b0;
        force1       = 1'b0;
        rr_last_d    = rr_last_q;
        starve_cnt_d = '0;

        if (!rst) begin
            if (RR_EN) begin
                if (elig0 && elig1) begin
                    grant0 = rr_last_q;
                    grant1 = !rr_last_q;
                end else begin
                    grant0 = elig0;
                    grant1 = elig1;
                end
            end else begin
                force1 = (starve_cnt_q >= STARVE_LIM);
                grant1 = elig1 && (!elig0 || force1);
                grant0 = elig0 && !grant1;
            end
        end

        if (grant0) rr_last_d = 1'b0;
        if (grant1) rr_last_d = 1'b1;

        // Counts only consecutive denied cycles; any gap in eligibility restarts it.
        if (!RR_EN && elig1 && !grant1)
            starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q    <= 1'b1;
            starve_cnt_q <= '0;
        end else begin
            rr_last_q    <= rr_last_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;
    assign alu_req  = grant1 ? req1 : req0;

    riscv_alu u_alu (
        .op1    (alu_req.op1),
        .op2    (alu_req.op2),
        .alu_op (alu_req.alu_op),
        .result (alu_result),
        .zero   (alu_zero_unused)
    );

    // Undefined op codes are still accepted but forced to a zero result flagged illegal.
    always_comb begin
        op_legal        = alu_op_legal(alu_req.alu_op);
        cap_rsp.result  = op_legal ? alu_result : 32'h0;
        cap_rsp.zero    = (cap_rsp.result == 32'h0);
        cap_rsp.illegal = !op_legal;
    end

    riscv_alu_rsp_slot u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant0),
        .load_data (cap_rsp),
        .rsp_ready (p0_rsp_ready),
        .rsp_valid (p0_rsp_valid),
        .rsp_data  (rsp0)
    );

    riscv_alu_rsp_slot u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant1),
        .load_data (cap_rsp),
        .rsp_ready (p1_rsp_ready),
        .rsp_valid (p1_rsp_valid),
        .rsp_data  (rsp1)
    );

    assign p0_rsp_result  = rsp0.result;
    assign p0_rsp_zero    = rsp0.zero;
    assign p0_rsp_illegal = rsp0.illegal;
    assign p1_rsp_result  = rsp1.result;
    assign p1_rsp_zero    = rsp1.zero;
    assign p1_rsp_illegal = rsp1.illegal;

endmodule
